regfile_lanes: RTL and testbench

- Parametrised multi-entry register file with byte-lane write modes and two registered read ports.
- Each read port has its own lane extraction: full word, zero-extend or sign-extend.
- A hardware clear sequencer zeroes every entry, one per cycle, on request.
- Used as the CPU's general register bank, replacing single fixed-width half-access registers.

---
 rtl/regfile_lanes.sv | 78 +++++++
 tb/tb_regfile_lanes.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_lanes.sv
// regfile_lanes: lane-addressable register file with two registered read ports
// and a one-entry-per-cycle hardware clear sweep.
module regfile_lanes #(
  parameter int WIDTH = 16,
  parameter int ADDR_W = 4,
  parameter int LW = $clog2(WIDTH / 8)
) (
  input  logic              C,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [1:0]        wmode,
  input  logic [LW-1:0]     wlane,
  input  logic [WIDTH-1:0]  D,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [1:0]        rmode_a,
  input  logic [LW-1:0]     rlane_a,
  output logic [WIDTH-1:0]  qa,
  input  logic [ADDR_W-1:0] raddr_b,
  input  logic [1:0]        rmode_b,
  input  logic [LW-1:0]     rlane_b,
  output logic [WIDTH-1:0]  qb
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int LANES = WIDTH / 8;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [WIDTH-1:0]  wdata;
  logic              wr_en;
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  function automatic logic [WIDTH-1:0] rd(input logic [WIDTH-1:0] w, input logic [1:0] m,
                                          input logic [LW-1:0] l);
    logic [7:0] b;
    b = (int'(l) < LANES) ? w[8*l +: 8] : 8'h00;
    return (m == 2'b01) ? {{(WIDTH-8){1'b0}}, b} : (m == 2'b10) ? {{(WIDTH-8){b[7]}}, b} : w;
  endfunction

  assign busy = (state_q == CLEAR);
  assign wr_en = we && !busy && (wmode == 2'b00 || (wmode != 2'b11 && int'(wlane) < LANES));
  assign state_d = (state_q == IDLE) ? (clr ? CLEAR : IDLE) : ((ptr_q == '1) ? IDLE : CLEAR);
  assign ptr_d = (state_q == CLEAR) ? ptr_q + ADDR_W'(1) : '0;

  always_comb begin
    wdata = mem_q[waddr];
    for (int l = 0; l < LANES; l++)
      if (l == int'(wlane)) wdata[8*l +: 8] = (wmode == 2'b01) ? D[7:0] : D[8*l +: 8];
    if (wmode == 2'b00) wdata = D;
  end

  // Writes and the sweep never coincide because writes are blocked while busy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      mem_d[i] = (busy && i == int'(ptr_q)) ? '0 : (wr_en && i == int'(waddr)) ? wdata : mem_q[i];
  end

  always_ff @(posedge C) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      qa <= '0;
      qb <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      qa <= rd(mem_d[raddr_a], rmode_a, rlane_a);
      qb <= rd(mem_d[raddr_b], rmode_b, rlane_b);
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end
endmodule

// File: tb/tb_regfile_lanes.sv
// tb_regfile_lanes: table vectors, hand-written clear/reset sequences and random
// stimulus checked against an array-based reference model.
module tb_regfile_lanes;
  logic        C = 1'b0;
  logic        rst, clr, we, busy;
  logic [3:0]  waddr, raddr_a, raddr_b;
  logic [1:0]  wmode, rmode_a, rmode_b;
  logic        wlane, rlane_a, rlane_b;
  logic [15:0] D, qa, qb;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_mem [16];
  logic [15:0] m_qa, m_qb;
  bit          m_busy;
  int          m_ptr;

  typedef struct {
    logic we; logic [3:0] wa; logic [1:0] wm; logic wl; logic [15:0] d;
    logic [3:0] ra; logic [1:0] ma; logic la;
    logic [3:0] rb; logic [1:0] mb; logic lb;
    logic [15:0] ea; logic [15:0] eb;
  } vec_t;

  always #5 C = ~C;

  regfile_lanes dut (
    .C(C), .rst(rst), .clr(clr), .busy(busy),
    .we(we), .waddr(waddr), .wmode(wmode), .wlane(wlane), .D(D),
    .raddr_a(raddr_a), .rmode_a(rmode_a), .rlane_a(rlane_a), .qa(qa),
    .raddr_b(raddr_b), .rmode_b(rmode_b), .rlane_b(rlane_b), .qb(qb)
  );

  function automatic logic [15:0] ref_read(input logic [15:0] w, input logic [1:0] m, input int l);
    int b;
    b = (l < 2) ? (int'(w) >> (8 * l)) & 255 : 0;
    if (m == 2'd1) return 16'(b);
    if (m == 2'd2) return 16'((b >= 128) ? b - 256 : b);
    return w;
  endfunction

  task automatic model_edge();
    logic [15:0] nxt [16];
    int sh, v;
    nxt = m_mem;
    if (rst) begin
      foreach (nxt[i]) nxt[i] = '0;
      m_busy = 0;
      m_ptr = 0;
      m_qa = '0;
      m_qb = '0;
    end else begin
      if (we && !m_busy && wmode == 2'd0) nxt[waddr] = D;
      if (we && !m_busy && (wmode == 2'd1 || wmode == 2'd2)) begin
        sh = 8 * int'(wlane);
        v = (wmode == 2'd1) ? int'(D) & 255 : (int'(D) >> sh) & 255;
        nxt[waddr] = 16'((int'(nxt[waddr]) & ~(255 << sh)) | (v << sh));
      end
      if (m_busy) begin
        nxt[m_ptr] = '0;
        m_ptr++;
        if (m_ptr == 16) begin
          m_busy = 0;
          m_ptr = 0;
        end
      end else if (clr) m_busy = 1;
      m_qa = ref_read(nxt[raddr_a], rmode_a, int'(rlane_a));
      m_qb = ref_read(nxt[raddr_b], rmode_b, int'(rlane_b));
    end
    m_mem = nxt;
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge C);
    model_edge();
    #1;
    check("qa_model", qa, m_qa);
    check("qb_model", qb, m_qb);
    check("busy_model", {15'b0, busy}, {15'b0, m_busy});
  endtask

  task automatic quiet();
    rst = 0; clr = 0; we = 0; waddr = 0; wmode = 0; wlane = 0; D = 0;
    raddr_a = 0; rmode_a = 0; rlane_a = 0; raddr_b = 0; rmode_b = 0; rlane_b = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    we = 1; waddr = a; wmode = 0; D = d;
    step();
    we = 0;
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < 16; i += 2) begin
      raddr_a = 4'(i); raddr_b = 4'(i + 1); rmode_a = 0; rmode_b = 0;
      step();
      check(name, qa, 16'h0000);
      check(name, qb, 16'h0000);
    end
  endtask

  vec_t tbl [10];

  initial begin
    foreach (m_mem[i]) m_mem[i] = '0;
    m_qa = '0; m_qb = '0; m_busy = 0; m_ptr = 0;
    tbl[0] = '{1, 3, 0, 0, 16'hBEEF, 3, 0, 0, 0, 0, 0, 16'hBEEF, 16'h0000};
    tbl[1] = '{1, 5, 0, 0, 16'h1234, 3, 0, 0, 5, 0, 0, 16'hBEEF, 16'h1234};
    tbl[2] = '{1, 5, 1, 1, 16'h00AB, 5, 0, 0, 3, 1, 0, 16'hAB34, 16'h00EF};
    tbl[3] = '{1, 5, 2, 0, 16'hFFCD, 5, 0, 0, 3, 2, 1, 16'hABCD, 16'hFFBE};
    tbl[4] = '{1, 5, 3, 0, 16'hFFFF, 5, 0, 0, 5, 1, 1, 16'hABCD, 16'h00AB};
    tbl[5] = '{1, 2, 0, 0, 16'h80F0, 2, 1, 1, 2, 2, 1, 16'h0080, 16'hFF80};
    tbl[6] = '{0, 2, 0, 0, 16'h0000, 2, 2, 0, 2, 3, 0, 16'hFFF0, 16'h80F0};
    tbl[7] = '{1, 7, 0, 0, 16'h5555, 7, 0, 0, 7, 1, 0, 16'h5555, 16'h0055};
    tbl[8] = '{1, 2, 2, 1, 16'h1200, 2, 0, 0, 3, 2, 0, 16'h12F0, 16'hFFEF};
    tbl[9] = '{1, 3, 1, 0, 16'hFF7F, 3, 2, 0, 3, 0, 0, 16'h007F, 16'hBE7F};

    quiet();
    rst = 1;
    step();
    step();
    check("reset_qa", qa, 16'h0000);
    check("reset_qb", qb, 16'h0000);
    check("reset_busy", {15'b0, busy}, 16'h0000);
    rst = 0;

    foreach (tbl[i]) begin
      we = tbl[i].we; waddr = tbl[i].wa; wmode = tbl[i].wm; wlane = tbl[i].wl; D = tbl[i].d;
      raddr_a = tbl[i].ra; rmode_a = tbl[i].ma; rlane_a = tbl[i].la;
      raddr_b = tbl[i].rb; rmode_b = tbl[i].mb; rlane_b = tbl[i].lb;
      step();
      check($sformatf("vec%0d_qa", i), qa, tbl[i].ea);
      check($sformatf("vec%0d_qb", i), qb, tbl[i].eb);
    end
    quiet();

    // Clear sweep: fill, start, poll entry 15, attempt writes and re-triggers while busy.
    for (int i = 0; i < 16; i++) wr(4'(i), 16'(16'h1111 * i + 16'h0101));
    raddr_a = 15;
    clr = 1;
    step();
    clr = 0;
    check("clr_busy_rise", {15'b0, busy}, 16'h0001);
    for (int j = 1; j < 16; j++) begin
      we = 1; waddr = 0; wmode = 0; D = 16'hFFFF;
      clr = (j >= 3 && j <= 5);
      step();
      check($sformatf("clr_busy_%0d", j), {15'b0, busy}, 16'h0001);
      check($sformatf("clr_poll15_%0d", j), qa, 16'hFFFF & 16'(16'h1111 * 15 + 16'h0101));
    end
    quiet();
    raddr_a = 15;
    step();
    check("clr_busy_fall", {15'b0, busy}, 16'h0000);
    check("clr_poll15_end", qa, 16'h0000);
    check_all_zero("clr_all_zero");

    // Reset in the middle of a sweep.
    for (int i = 0; i < 16; i++) wr(4'(i), 16'(16'hA5A5 ^ i));
    clr = 1;
    step();
    clr = 0;
    raddr_a = 12; raddr_b = 13;
    for (int j = 0; j < 4; j++) step();
    check("abort_busy_before", {15'b0, busy}, 16'h0001);
    rst = 1;
    step();
    rst = 0;
    check("abort_busy", {15'b0, busy}, 16'h0000);
    check("abort_qa", qa, 16'h0000);
    check("abort_qb", qb, 16'h0000);
    check_all_zero("abort_all_zero");
    wr(4'd9, 16'h3C5A);
    raddr_a = 9; rmode_a = 2; rlane_a = 1; raddr_b = 9;
    step();
    check("after_abort_qa", qa, 16'h003C);
    check("after_abort_qb", qb, 16'h3C5A);

    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      clr = ($urandom_range(0, 24) == 0);
      we = ($urandom_range(0, 3) != 0);
      waddr = 4'($urandom); wmode = 2'($urandom); wlane = 1'($urandom); D = 16'($urandom);
      raddr_a = 4'($urandom); rmode_a = 2'($urandom); rlane_a = 1'($urandom);
      raddr_b = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom);
      rmode_b = 2'($urandom); rlane_b = 1'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
